sha256_padder: RTL and testbench

//  Upstream neighbour of the block-input stage. Accepts a message as a stream of 32-bit big-endian words.

---
 rtl/sha256_pkg.sv | 14 +
 rtl/sha256_pad_word.sv | 19 +
 rtl/sha256_padder.sv | 148 ++++++++++++++
 tb/tb_sha256_padder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_PAD,
        ST_LEN,
        ST_EMIT
    } state_t;

    localparam int unsigned WORDS_PER_BLK = 16;
    localparam logic [31:0] PAD_WORD      = 32'h8000_0000;

endpackage

// File: rtl/sha256_pad_word.sv
// Masks a big-endian message word to its valid bytes and appends the 0x80 marker byte.
module sha256_pad_word (
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    output logic [31:0] out_word
);

    always_comb begin
        out_word = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            if (3'(b) < in_bytes) begin
                out_word[31-8*b -: 8] = in_data[31-8*b -: 8];
            end else if (3'(b) == in_bytes) begin
                out_word[31-8*b -: 8] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// Streams 32-bit message words into SHA-256 padded 512-bit blocks with the
// 64-bit message bit length carried in words 14-15 of the final block.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int unsigned LEN_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
);

    state_t             state_q, state_d;
    logic [3:0]         wptr_q, wptr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               pad_pend_q, pad_pend_d;
    logic               pad_phase_q, pad_phase_d;
    logic               blk_last_q, blk_last_d;
    logic [31:0]        blk_buf_q [WORDS_PER_BLK];
    logic [31:0]        blk_buf_d [WORDS_PER_BLK];

    logic [2:0]         eff_bytes;
    logic [31:0]        masked_word;
    logic [63:0]        len_ext;

    // Non-final words always carry four bytes, whatever in_bytes says.
    assign eff_bytes = (in_last && (in_bytes < 3'd4)) ? in_bytes : 3'd4;
    assign len_ext   = 64'(len_q);

    sha256_pad_word u_pad_word (
        .in_data  (in_data),
        .in_bytes (eff_bytes),
        .out_word (masked_word)
    );

    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        len_d       = len_q;
        pad_pend_d  = pad_pend_q;
        pad_phase_d = pad_phase_q;
        blk_last_d  = blk_last_q;
        blk_buf_d   = blk_buf_q;

        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    blk_buf_d[wptr_q] = masked_word;
                    len_d             = len_q + LEN_W'({eff_bytes, 3'b000});
                    wptr_d            = wptr_q + 4'd1;
                    if (in_last) begin
                        pad_pend_d  = (eff_bytes == 3'd4);
                        pad_phase_d = 1'b1;
                    end
                    if (wptr_q == 4'd15) begin
                        state_d    = ST_EMIT;
                        blk_last_d = 1'b0;
                    end else if (in_last) begin
                        state_d = ST_PAD;
                    end
                end
            end

            ST_PAD: begin
                // The marker word still owed after a full final word takes priority over the length slot.
                if (!pad_pend_q && (wptr_q == 4'd14)) begin
                    state_d = ST_LEN;
                end else begin
                    blk_buf_d[wptr_q] = pad_pend_q ? PAD_WORD : '0;
                    pad_pend_d        = 1'b0;
                    wptr_d            = wptr_q + 4'd1;
                    if (wptr_q == 4'd15) begin
                        state_d    = ST_EMIT;
                        blk_last_d = 1'b0;
                    end
                end
            end

            ST_LEN: begin
                blk_buf_d[14] = len_ext[63:32];
                blk_buf_d[15] = len_ext[31:0];
                wptr_d        = '0;
                blk_last_d    = 1'b1;
                state_d       = ST_EMIT;
            end

            ST_EMIT: begin
                if (blk_ready) begin
                    if (blk_last_q) begin
                        state_d     = ST_LOAD;
                        len_d       = '0;
                        pad_phase_d = 1'b0;
                        blk_last_d  = 1'b0;
                    end else if (pad_phase_q) begin
                        state_d = ST_PAD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            wptr_q      <= '0;
            len_q       <= '0;
            pad_pend_q  <= 1'b0;
            pad_phase_q <= 1'b0;
            blk_last_q  <= 1'b0;
            for (int unsigned i = 0; i < WORDS_PER_BLK; i++) begin
                blk_buf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            len_q       <= len_d;
            pad_pend_q  <= pad_pend_d;
            pad_phase_q <= pad_phase_d;
            blk_last_q  <= blk_last_d;
            for (int unsigned i = 0; i < WORDS_PER_BLK; i++) begin
                blk_buf_q[i] <= blk_buf_d[i];
            end
        end
    end

    assign in_ready  = (state_q == ST_LOAD);
    assign blk_valid = (state_q == ST_EMIT);
    assign blk_last  = blk_last_q;

    always_comb begin
        for (int unsigned i = 0; i < WORDS_PER_BLK; i++) begin
            blk_data[511-32*i -: 32] = blk_buf_q[i];
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// Scoreboard bench for sha256_padder: directed messages with hand-computed padded blocks.
module tb_sha256_padder;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_last;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
    } blk_t;

    blk_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sha256_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] setw(input logic [511:0] b, input int unsigned idx,
                                          input logic [31:0] w);
        logic [511:0] r;
        r = b;
        r[511-32*idx -: 32] = w;
        return r;
    endfunction

    function automatic logic [31:0] msg_word(input int unsigned i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Monitor: every accepted block is checked against the next expected one.
    always @(negedge clk) begin
        if (rst_n && blk_valid && blk_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_block", 512'(blk_valid), 512'(0));
            end else begin
                blk_t e;
                e = exp_q.pop_front();
                chk("blk_data", blk_data, e.data);
                chk("blk_last", 512'(blk_last), 512'(e.last));
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 512'(in_ready), 512'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 512'(exp_q.size()), 512'(0));
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!blk_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("valid_timeout", 512'(blk_valid), 512'(1));
    endtask

    task automatic push(input logic [511:0] d, input logic last);
        blk_t e;
        e.data = d;
        e.last = last;
        exp_q.push_back(e);
    endtask

    logic [511:0] abc_blk, b;
    int           cyc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        in_bytes  = '0;
        blk_ready = 1'b1;

        abc_blk = '0;
        abc_blk = setw(abc_blk, 0, 32'h6162_6380);
        abc_blk = setw(abc_blk, 15, 32'h0000_0018);

        repeat (3) @(negedge clk);
        chk("rst_blk_valid", 512'(blk_valid), 512'(0));
        chk("rst_in_ready", 512'(in_ready), 512'(1));
        chk("rst_blk_last", 512'(blk_last), 512'(0));
        chk("rst_blk_data", blk_data, 512'(0));
        rst_n = 1'b1;

        // "abc" with latency from the accept edge to blk_valid
        push(abc_blk, 1'b1);
        send_word(32'h6162_6300, 1'b1, 3'd3);
        cyc = 0;
        while (!blk_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("latency_abc", 512'(cyc), 512'(15));
        wait_drain();

        // Empty message
        b = '0;
        b = setw(b, 0, 32'h8000_0000);
        push(b, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1, 3'd0);
        wait_drain();

        // 55 bytes: 13 full words plus a 3-byte tail
        b = '0;
        for (int unsigned i = 0; i < 13; i++) b = setw(b, i, msg_word(i));
        b = setw(b, 13, 32'hC0DE_0080);
        b = setw(b, 15, 32'h0000_01B8);
        push(b, 1'b1);
        for (int unsigned i = 0; i < 14; i++) send_word(msg_word(i), (i == 13), (i == 13) ? 3'd3 : 3'd0);
        wait_drain();

        // 56 bytes: marker lands in word 14, length spills to a second block
        b = '0;
        for (int unsigned i = 0; i < 14; i++) b = setw(b, i, msg_word(i));
        b = setw(b, 14, 32'h8000_0000);
        push(b, 1'b0);
        b = '0;
        b = setw(b, 15, 32'h0000_01C0);
        push(b, 1'b1);
        for (int unsigned i = 0; i < 14; i++) send_word(msg_word(i), (i == 13), 3'd4);
        wait_drain();

        // 64 bytes: full data block, then marker + length block
        b = '0;
        for (int unsigned i = 0; i < 16; i++) b = setw(b, i, msg_word(i));
        push(b, 1'b0);
        b = '0;
        b = setw(b, 0, 32'h8000_0000);
        b = setw(b, 15, 32'h0000_0200);
        push(b, 1'b1);
        for (int unsigned i = 0; i < 16; i++) send_word(msg_word(i), (i == 15), 3'd4);
        wait_drain();

        // Back-pressure: hold EMIT for 10 cycles while offering input
        blk_ready = 1'b0;
        push(abc_blk, 1'b1);
        send_word(32'h6162_6300, 1'b1, 3'd3);
        wait_valid();
        in_valid = 1'b1;
        in_data  = 32'h5555_AAAA;
        in_last  = 1'b1;
        in_bytes = 3'd4;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_blk_data", blk_data, abc_blk);
            chk("bp_blk_last", 512'(blk_last), 512'(1));
            chk("bp_blk_valid", 512'(blk_valid), 512'(1));
            chk("bp_in_ready", 512'(in_ready), 512'(0));
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        blk_ready = 1'b1;
        wait_drain();
        @(negedge clk);
        chk("bp_idle_in_ready", 512'(in_ready), 512'(1));
        chk("bp_idle_blk_valid", 512'(blk_valid), 512'(0));

        // Reset in the middle of padding discards the partial message
        send_word(32'h1122_3344, 1'b1, 3'd4);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_blk_valid", 512'(blk_valid), 512'(0));
        chk("midrst_in_ready", 512'(in_ready), 512'(1));
        chk("midrst_blk_data", blk_data, 512'(0));
        @(negedge clk);
        rst_n = 1'b1;
        push(abc_blk, 1'b1);
        send_word(32'h6162_6300, 1'b1, 3'd3);
        wait_drain();

        repeat (5) @(negedge clk);
        chk("no_stray_blocks", 512'(exp_q.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
